// File: rtl/seg_scroll_if.sv
// Host-side control strobes plus display/status outputs for seg_scroll_ctrl.
// The host drives through the master modport; the controller attaches as slave.
interface seg_scroll_if #(
  parameter int NDIG  = 4,
  parameter int DEPTH = 16
) ();
  logic                         clr;
  logic                         wr_en;
  logic [3:0]                   wr_data;
  logic                         go;
  logic                         stop;
  logic [7*NDIG-1:0]            seg;
  logic [$clog2(DEPTH+1)-1:0]   count;
  logic                         full;
  logic                         busy;
  logic                         done;

  modport master (
    output clr, wr_en, wr_data, go, stop,
    input  seg, count, full, busy, done
  );

  modport slave (
    input  clr, wr_en, wr_data, go, stop,
    output seg, count, full, busy, done
  );
endinterface

// File: rtl/seg_scroll_ctrl.sv
// Scrolls a stored hex message right-to-left across NDIG active-low 7-segment digits.
// Optional macro SEG_SCROLL_ONESHOT_EN: stop after one full pass and pulse done.
module seg_scroll_ctrl #(
  parameter int NDIG     = 4,
  parameter int DEPTH    = 16,
  parameter int TICK_DIV = 12500000
) (
  input logic        clk,
  input logic        rst,
  seg_scroll_if.slave bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = $clog2(DEPTH + NDIG);
  localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, SCROLL, HOLD} state_t;

  state_t            state, state_next;
  logic [DW-1:0]     divider, divider_next;
  logic [PW-1:0]     pos, pos_next;
  logic [CW-1:0]     count;
  logic [3:0]        msg_buf [DEPTH];
  logic [7*NDIG-1:0] seg_q, seg_next;
  logic              busy;
  logic              go_eff;
  logic              write_ok;
  logic              tick;
  logic [PW:0]       period;
  logic [PW:0]       pos_inc;
  logic [PW-1:0]     pos_step;
  logic [PW:0]       idx;
`ifdef SEG_SCROLL_ONESHOT_EN
  logic              done_next;
  logic              done_q;
`endif

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b0000001;
      4'h1: hex7 = 7'b1001111;
      4'h2: hex7 = 7'b0010010;
      4'h3: hex7 = 7'b0000110;
      4'h4: hex7 = 7'b1001100;
      4'h5: hex7 = 7'b0100100;
      4'h6: hex7 = 7'b0100000;
      4'h7: hex7 = 7'b0001111;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0001100;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b1100000;
      4'hC: hex7 = 7'b0110001;
      4'hD: hex7 = 7'b1000010;
      4'hE: hex7 = 7'b0110000;
      default: hex7 = 7'b0111000;
    endcase
  endfunction

  // stop outranks go; a go that starts scrolling swallows a same-cycle write
  assign go_eff   = bus.go && !bus.stop;
  assign write_ok = (state == IDLE) && bus.wr_en && !bus.clr &&
                    (count < CW'(DEPTH)) && !(go_eff && (count != '0));
  assign period   = (PW+1)'(count) + (PW+1)'(NDIG);
  assign pos_inc  = (PW+1)'(pos) + (PW+1)'(1);
  assign pos_step = (pos_inc == period) ? '0 : pos_inc[PW-1:0];
  assign tick     = (divider == DW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next   = state;
    pos_next     = pos;
    divider_next = divider;
`ifdef SEG_SCROLL_ONESHOT_EN
    done_next    = 1'b0;
`endif
    if (bus.clr) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (go_eff && (count != '0)) begin
            state_next   = SCROLL;
            pos_next     = PW'(count);
            divider_next = '0;
          end
        end
        SCROLL: begin
          if (bus.stop) begin
            state_next = HOLD;
          end else if (tick) begin
            divider_next = '0;
`ifdef SEG_SCROLL_ONESHOT_EN
            // returning to pos == L means the whole message has passed through
            if (pos_step == PW'(count)) begin
              state_next = IDLE;
              done_next  = 1'b1;
            end else begin
              pos_next = pos_step;
            end
`else
            pos_next = pos_step;
`endif
          end else begin
            divider_next = divider + DW'(1);
          end
        end
        HOLD: begin
          if (bus.stop)    state_next = IDLE;
          else if (bus.go) state_next = SCROLL;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    busy     = (state != IDLE);
    seg_next = '1;
    idx      = '0;
    if (state != IDLE) begin
      for (int k = 0; k < NDIG; k++) begin
        idx = (PW+1)'(pos) + (PW+1)'(k);
        if (idx >= period) idx = idx - period;
        if (idx < (PW+1)'(count))
          seg_next[7*(NDIG-1-k) +: 7] = hex7(msg_buf[idx[AW-1:0]]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pos     <= '0;
      divider <= '0;
      count   <= '0;
      seg_q   <= '1;
    end else begin
      pos     <= pos_next;
      divider <= divider_next;
      seg_q   <= seg_next;
      if (bus.clr)       count <= '0;
      else if (write_ok) count <= count + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && write_ok) msg_buf[count[AW-1:0]] <= bus.wr_data;
  end

`ifdef SEG_SCROLL_ONESHOT_EN
  always_ff @(posedge clk) begin
    if (rst) done_q <= 1'b0;
    else     done_q <= done_next;
  end
  assign bus.done = done_q;
`else
  assign bus.done = 1'b0;
`endif

  assign bus.seg   = seg_q;
  assign bus.count = count;
  assign bus.full  = (count == CW'(DEPTH));
  assign bus.busy  = busy;

endmodule

// File: tb/tb_seg_scroll_ctrl.sv
// Scoreboard bench for seg_scroll_ctrl: a message-queue reference model predicts every cycle.
// Build with SEG_SCROLL_ONESHOT_EN defined to exercise the single-pass variant.
module tb_seg_scroll_ctrl;

  localparam int NDIG  = 4;
  localparam int DEPTH = 16;
  localparam int TICK  = 4;
  localparam logic [27:0] BLANK = 28'hFFFFFFF;
  localparam int M_IDLE = 0, M_SCROLL = 1, M_HOLD = 2;

  typedef struct packed {
    logic [27:0] seg;
    logic [4:0]  count;
    logic        full;
    logic        busy;
    logic        done;
  } exp_t;

  logic clk;
  logic rst;

  seg_scroll_if #(.NDIG(NDIG), .DEPTH(DEPTH)) bus ();

  seg_scroll_ctrl #(.NDIG(NDIG), .DEPTH(DEPTH), .TICK_DIV(TICK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];

  logic [6:0] GLYPH [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  int          m_state, m_pos, m_div, m_len, m_nxt;
  logic [3:0]  m_msg[$];
  logic        m_done;
  logic [27:0] m_seg, m_seg_new;
  exp_t        m_exp;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // The displayed window is the message followed by NDIG blanks, viewed cyclically.
  function automatic logic [27:0] model_window();
    logic [27:0] w;
    int len;
    int per;
    int j;
    w   = BLANK;
    len = m_msg.size();
    per = len + NDIG;
    for (int k = 0; k < NDIG; k++) begin
      j = (m_pos + k) % per;
      if (j < len) w[7*(NDIG-1-k) +: 7] = GLYPH[m_msg[j]];
    end
    return w;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] want);
    checks++;
    if (actual !== want) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, want, $time);
    end
  endtask

  // Reference model: predicts the outputs after each rising edge and queues them.
  initial begin
    m_state = M_IDLE; m_pos = 0; m_div = 0; m_done = 1'b0; m_seg = BLANK;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_state = M_IDLE; m_pos = 0; m_div = 0; m_done = 1'b0; m_seg = BLANK;
        m_msg.delete();
      end else begin
        m_seg_new = (m_state == M_IDLE) ? BLANK : model_window();
        m_len     = m_msg.size();
        m_done    = 1'b0;
        if (bus.clr) begin
          m_msg.delete();
          m_state = M_IDLE;
        end else if (m_state == M_IDLE) begin
          if (bus.go && !bus.stop && m_len > 0) begin
            m_state = M_SCROLL; m_pos = m_len; m_div = 0;
          end else if (bus.wr_en && m_len < DEPTH) begin
            m_msg.push_back(bus.wr_data);
          end
        end else if (m_state == M_SCROLL) begin
          if (bus.stop) begin
            m_state = M_HOLD;
          end else if (m_div == TICK - 1) begin
            m_div = 0;
            m_nxt = (m_pos + 1) % (m_len + NDIG);
`ifdef SEG_SCROLL_ONESHOT_EN
            if (m_nxt == m_len) begin
              m_state = M_IDLE;
              m_done  = 1'b1;
            end else begin
              m_pos = m_nxt;
            end
`else
            m_pos = m_nxt;
`endif
          end else begin
            m_div++;
          end
        end else begin
          if (bus.stop)    m_state = M_IDLE;
          else if (bus.go) m_state = M_SCROLL;
        end
        m_seg = m_seg_new;
      end
      m_exp.seg   = m_seg;
      m_exp.count = 5'(m_msg.size());
      m_exp.full  = (m_msg.size() == DEPTH);
      m_exp.busy  = (m_state != M_IDLE);
      m_exp.done  = m_done;
      exp_q.push_back(m_exp);
    end
  end

  // Monitor: compares every prediction against the DUT on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("sb_seg",   32'(bus.seg),   32'(e.seg));
        checkOutput("sb_count", 32'(bus.count), 32'(e.count));
        checkOutput("sb_full",  32'(bus.full),  32'(e.full));
        checkOutput("sb_busy",  32'(bus.busy),  32'(e.busy));
        checkOutput("sb_done",  32'(bus.done),  32'(e.done));
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: run did not complete, got timeout, expected finish");
    $fatal(1);
  end

  task automatic applyStimulus(input logic c, input logic w, input logic [3:0] d,
                               input logic g, input logic s);
    bus.clr = c; bus.wr_en = w; bus.wr_data = d; bus.go = g; bus.stop = s;
    @(negedge clk);
    bus.clr = 1'b0; bus.wr_en = 1'b0; bus.go = 1'b0; bus.stop = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic waitSeg(input string name, input logic [27:0] want, input int budget);
    int n = 0;
    while (bus.seg !== want && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, 32'(bus.seg), 32'(want));
  endtask

  initial begin
    int r;
    int n;
    rst = 1'b1;
    bus.clr = 1'b0; bus.wr_en = 1'b0; bus.wr_data = 4'h0; bus.go = 1'b0; bus.stop = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_seg",   32'(bus.seg),   32'(BLANK));
    checkOutput("rst_count", 32'(bus.count), 32'd0);
    checkOutput("rst_full",  32'(bus.full),  32'd0);
    checkOutput("rst_busy",  32'(bus.busy),  32'd0);
    rst = 1'b0;
    idle(1);

    // message 1,2,3 enters from the right
    applyStimulus(0, 1, 4'h1, 0, 0);
    applyStimulus(0, 1, 4'h2, 0, 0);
    applyStimulus(0, 1, 4'h3, 0, 0);
    applyStimulus(0, 0, 4'h0, 1, 0);
    idle(2);
    checkOutput("go_busy",  32'(bus.busy), 32'd1);
    checkOutput("go_blank", 32'(bus.seg),  32'(BLANK));
    waitSeg("step1", {7'h7F, 7'h7F, 7'h7F, 7'b1001111}, 20);
    waitSeg("step3", {7'h7F, 7'b1001111, 7'b0010010, 7'b0000110}, 20);

    // freeze, resume, then double stop
    applyStimulus(0, 0, 4'h0, 0, 1);
    idle(20);
    applyStimulus(0, 0, 4'h0, 1, 0);
    idle(12);
    applyStimulus(0, 0, 4'h0, 0, 1);
    applyStimulus(0, 0, 4'h0, 0, 1);
    idle(2);
    checkOutput("stop2_busy", 32'(bus.busy), 32'd0);
    checkOutput("stop2_seg",  32'(bus.seg),  32'(BLANK));

    // go+stop while scrolling holds, clr from HOLD empties
    applyStimulus(0, 0, 4'h0, 1, 0);
    idle(3);
    applyStimulus(0, 0, 4'h0, 1, 1);
    idle(5);
    checkOutput("gostop_busy", 32'(bus.busy), 32'd1);
    applyStimulus(1, 0, 4'h0, 0, 0);
    idle(2);
    checkOutput("clr_count", 32'(bus.count), 32'd0);
    checkOutput("clr_busy",  32'(bus.busy),  32'd0);

    // go on empty buffer is ignored; same-cycle write still lands
    applyStimulus(0, 1, 4'h5, 1, 0);
    idle(2);
    checkOutput("go_empty_busy",  32'(bus.busy),  32'd0);
    checkOutput("go_empty_count", 32'(bus.count), 32'd1);
    applyStimulus(0, 1, 4'h6, 1, 0);
    idle(2);
    checkOutput("go_wr_count", 32'(bus.count), 32'd1);
    checkOutput("go_wr_busy",  32'(bus.busy),  32'd1);
    applyStimulus(1, 0, 4'h0, 0, 0);

    // fill to capacity and overflow by one
    for (int i = 0; i < DEPTH + 1; i++)
      applyStimulus(0, 1, 4'($urandom_range(0, 15)), 0, 0);
    idle(1);
    checkOutput("full_count", 32'(bus.count), 32'd16);
    checkOutput("full_flag",  32'(bus.full),  32'd1);
    applyStimulus(0, 0, 4'h0, 1, 0);
    idle(17 * TICK + 4);

    // reset held mid-scroll
    pulseReset();
    checkOutput("midrst_seg",   32'(bus.seg),   32'(BLANK));
    checkOutput("midrst_count", 32'(bus.count), 32'd0);
    checkOutput("midrst_full",  32'(bus.full),  32'd0);
    checkOutput("midrst_busy",  32'(bus.busy),  32'd0);

    applyStimulus(0, 1, 4'hA, 0, 0);
    applyStimulus(0, 1, 4'hB, 0, 0);
    applyStimulus(0, 0, 4'h0, 1, 0);
`ifdef SEG_SCROLL_ONESHOT_EN
    n = 0;
    while (bus.done !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    checkOutput("oneshot_done", 32'(bus.done), 32'd1);
    checkOutput("oneshot_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    checkOutput("oneshot_seg",  32'(bus.seg),  32'(BLANK));
`else
    n = 0;
    idle(10 * TICK);
    checkOutput("loop_busy", 32'(bus.busy) + 32'(n), 32'd1);
`endif
    applyStimulus(1, 0, 4'h0, 0, 0);

    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 1)       pulseReset();
      else if (r < 4)  applyStimulus(1, 0, 4'h0, 0, 0);
      else if (r < 30) applyStimulus(0, 1, 4'($urandom_range(0, 15)), 0, 0);
      else if (r < 40) applyStimulus(0, $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)), 1, 0);
      else if (r < 46) applyStimulus(0, 0, 4'h0, 0, 1);
      else if (r < 48) applyStimulus(0, 0, 4'h0, 1, 1);
      else             idle(1 + $urandom_range(0, 7));
    end

    idle(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
